// File: rtl/rv_regfile_sb.sv
// Integer register file: two combinational read ports, one write port and a busy-bit scoreboard.
// Define RV_REGFILE_BYPASS_EN to forward same-cycle writeback data onto the read ports.
module rv_regfile_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            iss_en,
    input  logic [AW-1:0]   iss_rd,
    input  logic            flush,
    output logic            dbl_iss_err
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_next;
    logic             wr_live;
    logic             iss_live;

    assign wr_live  = wr_en && (wr_addr != '0);
    assign iss_live = iss_en && (iss_rd != '0);

    // Reservation is applied after the release so a same-edge issue wins over writeback.
    always_comb begin
        busy_next = busy;
        if (flush) begin
            busy_next = '0;
        end else begin
            if (wr_live)  busy_next[wr_addr] = 1'b0;
            if (iss_live) busy_next[iss_rd]  = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            busy        <= '0;
            dbl_iss_err <= 1'b0;
        end else begin
            if (wr_live) regs[wr_addr] <= wr_data;
            busy <= busy_next;
            if (!flush && iss_live && busy[iss_rd]) dbl_iss_err <= 1'b1;
        end
    end

    always_comb begin
        rs1_data = regs[rs1_addr];
        rs1_busy = busy[rs1_addr];
        rs2_data = regs[rs2_addr];
        rs2_busy = busy[rs2_addr];
        if (rs1_addr == '0) begin
            rs1_data = '0;
            rs1_busy = 1'b0;
        end
        if (rs2_addr == '0) begin
            rs2_data = '0;
            rs2_busy = 1'b0;
        end
`ifdef RV_REGFILE_BYPASS_EN
        if (wr_live && (rs1_addr == wr_addr)) begin
            rs1_data = wr_data;
            rs1_busy = 1'b0;
        end
        if (wr_live && (rs2_addr == wr_addr)) begin
            rs2_data = wr_data;
            rs2_busy = 1'b0;
        end
`endif
    end

endmodule

// File: tb/tb_rv_regfile_sb.sv
// Self-checking bench for rv_regfile_sb: directed scenarios plus randomized traffic against a
// behavioural model; a second small instance covers XLEN=16, NREGS=8.
module tb_rv_regfile_sb;

    logic        clk = 1'b0;
    logic        clk_en = 1'b0;
    logic        rst;
    logic [4:0]  rs1_addr, rs2_addr, wr_addr, iss_rd;
    logic [31:0] rs1_data, rs2_data, wr_data;
    logic        rs1_busy, rs2_busy, wr_en, iss_en, flush, dbl_iss_err;

    logic [2:0]  s_rs1_addr, s_rs2_addr, s_wr_addr, s_iss_rd;
    logic [15:0] s_rs1_data, s_rs2_data, s_wr_data;
    logic        s_rs1_busy, s_rs2_busy, s_wr_en, s_iss_en, s_flush, s_err;

    int checks = 0;
    int failures = 0;

    // Reference state, updated from the register-file rules at each rising edge
    logic [31:0] m_regs [32];
    logic [31:0] m_busy;
    logic        m_err;

    always #5 if (clk_en) clk = ~clk;

    rv_regfile_sb dut (
        .clk(clk), .rst(rst),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_rd(iss_rd), .flush(flush),
        .dbl_iss_err(dbl_iss_err)
    );

    rv_regfile_sb #(.XLEN(16), .NREGS(8)) u_small (
        .clk(clk), .rst(rst),
        .rs1_addr(s_rs1_addr), .rs2_addr(s_rs2_addr),
        .rs1_data(s_rs1_data), .rs2_data(s_rs2_data),
        .rs1_busy(s_rs1_busy), .rs2_busy(s_rs2_busy),
        .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
        .iss_en(s_iss_en), .iss_rd(s_iss_rd), .flush(s_flush),
        .dbl_iss_err(s_err)
    );

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_busy = '0;
        m_err  = 1'b0;
    endtask

    task automatic model_edge();
        logic [31:0] old_busy;
        old_busy = m_busy;
        if (wr_en && wr_addr != 0) m_regs[wr_addr] = wr_data;
        if (flush) begin
            m_busy = '0;
        end else begin
            if (wr_en && wr_addr != 0) m_busy[wr_addr] = 1'b0;
            if (iss_en && iss_rd != 0) begin
                if (old_busy[iss_rd]) m_err = 1'b1;
                m_busy[iss_rd] = 1'b1;
            end
        end
    endtask

    function automatic logic [31:0] exp_data(input logic [4:0] a);
        if (a == 0) return '0;
`ifdef RV_REGFILE_BYPASS_EN
        if (wr_en && wr_addr == a) return wr_data;
`endif
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (a == 0) return 1'b0;
`ifdef RV_REGFILE_BYPASS_EN
        if (wr_en && wr_addr == a) return 1'b0;
`endif
        return m_busy[a];
    endfunction

    // Carry the current inputs across one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 0; wr_addr = 0; wr_data = 0;
        iss_en = 0; iss_rd = 0; flush = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        rs1_addr = 5; rs2_addr = 31;
        s_rs1_addr = 0; s_rs2_addr = 0; s_wr_en = 0; s_wr_addr = 0; s_wr_data = 0;
        s_iss_en = 0; s_iss_rd = 0; s_flush = 0;
        model_reset();
        #3;
        checks++;
        if (rs1_data !== 32'h0 || rs2_data !== 32'h0 || rs1_busy !== 1'b0 || rs2_busy !== 1'b0 || dbl_iss_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_hold: got d1=%h d2=%h b1=%b b2=%b err=%b, want all zero",
                     rs1_data, rs2_data, rs1_busy, rs2_busy, dbl_iss_err);
        end
        clk_en = 1'b1;
        #7 rst = 1'b0;
        @(posedge clk); #1;
        wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF;
        tick();
        idle_inputs();
        #1;
        checks++;
        if (rs1_data !== 32'hDEADBEEF) begin
            failures++;
            $display("[TB] FAIL pre_reset_write: got %h want deadbeef", rs1_data);
        end
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (rs1_data !== 32'h0) begin
            failures++;
            $display("[TB] FAIL async_reset_clears: got %h want 0", rs1_data);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        wr_en = 1; wr_addr = 31; wr_data = 32'h12345678;
        rs1_addr = 31; rs2_addr = 31;
        #1;
        checks++;
        if (rs1_data !== exp_data(31)) begin
            failures++;
            $display("[TB] FAIL write_cycle_read: got %h want %h", rs1_data, exp_data(31));
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (rs1_data !== 32'h12345678 || rs2_data !== 32'h12345678) begin
            failures++;
            $display("[TB] FAIL write_read_x31: got %h/%h want 12345678", rs1_data, rs2_data);
        end
        wr_en = 1; wr_addr = 0; wr_data = 32'hFFFFFFFF;
        tick();
        idle_inputs();
        rs1_addr = 0; rs2_addr = 0;
        #1;
        checks++;
        if (rs1_data !== 32'h0 || rs2_data !== 32'h0 || rs1_busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL x0_write_ignored: got %h/%h busy=%b want 0", rs1_data, rs2_data, rs1_busy);
        end
    endtask

    task automatic test_scoreboard();
        rs1_addr = 7; rs2_addr = 7;
        iss_en = 1; iss_rd = 7;
        tick();
        idle_inputs();
        #1;
        checks++;
        if (rs1_busy !== 1'b1 || dbl_iss_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL issue_sets_busy: got busy=%b err=%b want 1/0", rs1_busy, dbl_iss_err);
        end
        wr_en = 1; wr_addr = 7; wr_data = 32'hA5;
        tick();
        idle_inputs();
        #1;
        checks++;
        if (rs1_busy !== 1'b0 || rs1_data !== 32'hA5 || dbl_iss_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL writeback_release: got busy=%b data=%h err=%b want 0/a5/0", rs1_busy, rs1_data, dbl_iss_err);
        end
        iss_en = 1; iss_rd = 7;
        tick();
        #1;
        checks++;
        if (dbl_iss_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_issue_no_err: got %b want 0", dbl_iss_err);
        end
        tick();
        idle_inputs();
        repeat (3) tick();
        checks++;
        if (dbl_iss_err !== m_err || m_err !== 1'b1) begin
            failures++;
            $display("[TB] FAIL double_issue_sticky: got %b want 1", dbl_iss_err);
        end
    endtask

    task automatic test_collision();
        rs1_addr = 9; rs2_addr = 3;
        iss_en = 1; iss_rd = 9; wr_en = 1; wr_addr = 9; wr_data = 32'h55;
        tick();
        idle_inputs();
        #1;
        checks++;
        if (rs1_data !== 32'h55 || rs1_busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL issue_wins_release: got data=%h busy=%b want 55/1", rs1_data, rs1_busy);
        end
        iss_en = 1; iss_rd = 10;
        tick();
        flush = 1; iss_en = 1; iss_rd = 3; wr_en = 1; wr_addr = 12; wr_data = 32'hC0FFEE;
        tick();
        idle_inputs();
        for (int a = 0; a < 32; a++) begin
            rs1_addr = 5'(a);
            #1;
            checks++;
            if (rs1_busy !== 1'b0) begin
                failures++;
                $display("[TB] FAIL flush_clears_busy x%0d: got %b want 0", a, rs1_busy);
            end
        end
        rs2_addr = 12;
        #1;
        checks++;
        if (rs2_data !== 32'hC0FFEE) begin
            failures++;
            $display("[TB] FAIL flush_keeps_write: got %h want c0ffee", rs2_data);
        end
    endtask

    task automatic test_bypass();
        wr_en = 1; wr_addr = 4; wr_data = 32'h11;
        tick();
        idle_inputs();
        iss_en = 1; iss_rd = 4;
        tick();
        idle_inputs();
        rs2_addr = 4;
        wr_en = 1; wr_addr = 4; wr_data = 32'h77;
        #1;
        checks++;
`ifdef RV_REGFILE_BYPASS_EN
        if (rs2_data !== 32'h77 || rs2_busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bypass_same_cycle: got %h busy=%b want 77/0", rs2_data, rs2_busy);
        end
`else
        if (rs2_data !== 32'h11 || rs2_busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL no_bypass_old_value: got %h busy=%b want 11/1", rs2_data, rs2_busy);
        end
`endif
        tick();
        idle_inputs();
        #1;
        checks++;
        if (rs2_data !== 32'h77 || rs2_busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL write_next_cycle: got %h busy=%b want 77/0", rs2_data, rs2_busy);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            wr_en   = ($urandom_range(0, 99) < 50);
            wr_addr = 5'($urandom);
            wr_data = $urandom;
            iss_en  = ($urandom_range(0, 99) < 40);
            iss_rd  = 5'($urandom);
            flush   = ($urandom_range(0, 99) < 4);
            rs1_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom);
            rs2_addr = ($urandom_range(0, 3) == 0) ? iss_rd : 5'($urandom);
            #1;
            checks++;
            if (rs1_data !== exp_data(rs1_addr) || rs1_busy !== exp_busy(rs1_addr)) begin
                failures++;
                $display("[TB] FAIL random_rs1 n=%0d x%0d: got %h/%b want %h/%b",
                         n, rs1_addr, rs1_data, rs1_busy, exp_data(rs1_addr), exp_busy(rs1_addr));
            end
            checks++;
            if (rs2_data !== exp_data(rs2_addr) || rs2_busy !== exp_busy(rs2_addr)) begin
                failures++;
                $display("[TB] FAIL random_rs2 n=%0d x%0d: got %h/%b want %h/%b",
                         n, rs2_addr, rs2_data, rs2_busy, exp_data(rs2_addr), exp_busy(rs2_addr));
            end
            checks++;
            if (dbl_iss_err !== m_err) begin
                failures++;
                $display("[TB] FAIL random_err n=%0d: got %b want %b", n, dbl_iss_err, m_err);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_param_sweep();
        logic [3:0]  wide;
        logic [15:0] exp;
        for (int a = 0; a < 8; a++) begin
            s_wr_en = 1; s_wr_addr = 3'(a); s_wr_data = (a == 7) ? 16'hBEEF : 16'(a * 16'h1111);
            @(posedge clk); #1;
        end
        s_wr_en = 0;
        s_iss_en = 1; s_iss_rd = 0;
        @(posedge clk); #1;
        s_iss_en = 0;
        for (int a = 0; a < 8; a++) begin
            s_rs1_addr = 3'(a); s_rs2_addr = 3'(7 - a);
            exp = (a == 0) ? 16'h0 : (a == 7) ? 16'hBEEF : 16'(a * 16'h1111);
            #1;
            checks++;
            if (s_rs1_data !== exp || s_rs1_busy !== 1'b0) begin
                failures++;
                $display("[TB] FAIL small_read x%0d: got %h/%b want %h/0", a, s_rs1_data, s_rs1_busy, exp);
            end
        end
        wide = 4'd15;
        s_rs2_addr = wide[2:0];
        #1;
        checks++;
        if (s_rs2_data !== 16'hBEEF || s_rs2_busy !== 1'b0 || s_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL small_wrap_x7: got %h busy=%b err=%b want beef/0/0", s_rs2_data, s_rs2_busy, s_err);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_scoreboard();
        test_collision();
        test_bypass();
        test_random();
        test_param_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rv_regfile_sb.md
# rv_regfile_sb

Parametrised register file with two combinational read ports, one synchronous write port and a per-register scoreboard of busy bits. It is the next-generation integer register file for the pipelined RISC-V core: decode reads operands and busy flags, issue reserves the destination, and writeback stores the result and releases the reservation. Register 0 is hard-wired to zero. An optional write-to-read bypass is selected at compile time.

## Interface
- XLEN, 32, data width in bits (≥8)
- NREGS, 32, number of architectural registers (power of two, ≥2)
- AW, $clog2(NREGS), address width (derived, not overridden)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- rs1_addr  in  AW  read port 1 address
- rs2_addr  in  AW  read port 2 address
- rs1_data  out  XLEN  read port 1 data
- rs2_data  out  XLEN  read port 2 data
- rs1_busy  out  1  register at rs1_addr has a pending write
- rs2_busy  out  1  register at rs2_addr has a pending write
- wr_en  in  1  writeback strobe
- wr_addr  in  AW  writeback destination
- wr_data  in  XLEN  writeback data
- iss_en  in  1  reserve a destination (set busy)
- iss_rd  in  AW  destination being reserved
- flush  in  1  clear all busy bits (pipeline squash)
- dbl_iss_err  out  1  sticky: iss_en hit a register that was already busy

## Operation
- Storage: NREGS x XLEN array plus NREGS busy bits; entry 0 is never written and is never busy.
- Reads: combinational. rsN_data = array[rsN_addr], rsN_busy = busy[rsN_addr]. Address 0 returns data 0 and busy 0.
- Write: on a rising edge with wr_en=1 and wr_addr≠0, array[wr_addr] <= wr_data and busy[wr_addr] <= 0. wr_addr=0 is silently ignored.
- Issue: on a rising edge with iss_en=1 and iss_rd≠0, busy[iss_rd] <= 1. If busy[iss_rd] was already 1, dbl_iss_err <= 1. It stays set until reset.
- Same edge, iss_rd == wr_addr ≠ 0: the data write happens and busy ends at 1, because the new reservation wins over the release.
- flush=1 on an edge clears every busy bit. Any iss_en on that same edge is dropped. A wr_en on that same edge still writes data. dbl_iss_err is not evaluated during a flush.
- A write to a register that is not busy is legal and does not flag an error.

## Timing
- Reset (asynchronous): all array entries = 0, all busy = 0, dbl_iss_err = 0. Outputs therefore read 0/0/0 within the reset assertion, with no clock needed.
- Reset released mid-operation: any state from before reset is lost. The first edge after deassertion behaves normally.
- Write latency is 1 cycle. Without bypass, a read of wr_addr in the write cycle returns the old value, and the new value appears after the edge.
- Issue latency is 1 cycle: busy is visible on the read ports from the cycle after iss_en.
- Both read ports are fully independent. Equal addresses on both ports return identical data.

## Configuration
- RV_REGFILE_BYPASS_EN defined:
  - If wr_en=1, wr_addr≠0 and rsN_addr==wr_addr, then rsN_data = wr_data and rsN_busy = 0 in that same cycle. This is purely combinational forwarding.
  - A same-cycle iss_en to that register does not affect the forwarded busy, because issue takes effect next cycle.
- Macro undefined: reads return registered state only, with the 1-cycle write visibility described above.

## Test plan
- Reset hold: assert rst with no clock -> all reads give 0, both busy flags 0, dbl_iss_err=0. Write 0xDEADBEEF to x5, pulse rst -> reading x5 gives 0.
- Write/read: write 0x12345678 to x31 -> from the next cycle rs1_data and rs2_data both read 0x12345678. Write 0xFFFFFFFF to x0 -> x0 still reads 0.
- Scoreboard: issue x7 -> rs1_busy=1 next cycle. Write 0xA5 to x7 -> busy=0 and data=0xA5 next cycle. Issue x7 twice without a writeback -> dbl_iss_err=1 and it stays set.
- Collision: on one edge, issue x9 together with a write of 0x55 to x9 -> x9 reads 0x55 and busy=1. Flush together with issue of x3 -> all busy bits 0 and x3 not busy.
- Bypass (with RV_REGFILE_BYPASS_EN): wr_en on x4 with 0x77 and rs2_addr=4 in the same cycle -> rs2_data=0x77 and rs2_busy=0 combinationally. Without the macro -> old value in that cycle, 0x77 next cycle.
- Parameter sweep: XLEN=16, NREGS=8 -> writing 0xBEEF to x7 reads back 0xBEEF. Addresses wrap within 3 bits, and x0 rules still hold.
